// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller: scan state encoding,
// BCD nibble width and helpers for the digit-select constant and counter width.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg_state_e;

    localparam int SEG_NIB_W      = 4;
    localparam int SEG_MAX_DIGITS = 8;

    // Active-low select pattern with every digit position turned off.
    function automatic logic [SEG_MAX_DIGITS-1:0] seg_all_off(input int digits);
        logic [SEG_MAX_DIGITS-1:0] m;
        m = '0;
        for (int k = 0; k < SEG_MAX_DIGITS; k++) begin
            if (k < digits) m[k] = 1'b1;
        end
        return m;
    endfunction

    // Phase counter width: wide enough to hold the larger terminal value.
    function automatic int seg_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seg_phase_cnt.sv
// Phase counter for the scan sequencer. Counts up from 0 to the supplied
// terminal value, flags the terminal cycle and wraps back to 0.
module seg_phase_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == tc_val);

    // Advance the count, restarting at 0 after the terminal cycle.
    always_comb begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end

    // Count register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller driving one shared BCD-to-7-segment
// decoder across DIGITS common-anode positions. New display words are
// taken through a one-deep pending slot and swapped in only at frame end.
// Optional build macro SEG_LZB_EN: leading-zero blanking of the upper digits.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | all digits off for BLANK_CYC cycles; seg_data already set
//   ST_SHOW  | digit idx enabled for DWELL_CYC cycles; last one of the
//            | top digit is the frame end
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          upd_valid,
    input  logic [SEG_NIB_W*DIGITS-1:0]   upd_data,
    output logic                          upd_ready,
    output logic [SEG_NIB_W-1:0]          seg_data,
    output logic [DIGITS-1:0]             seg_sel,
    output logic                          frame_done
);

    localparam int WORD_W = SEG_NIB_W * DIGITS;
    localparam int CNT_W  = seg_cnt_w(DWELL_CYC, BLANK_CYC);
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]          BLANK_TC = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0]          DWELL_TC = CNT_W'(DWELL_CYC - 1);
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [SEG_MAX_DIGITS-1:0] ALL_OFF  = seg_all_off(DIGITS);

    seg_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  active_q, active_d;
    logic [WORD_W-1:0]  pending_q, pending_d;
    logic               pend_vld_q, pend_vld_d;
    logic [SEG_NIB_W-1:0] seg_data_q, seg_data_d;

    logic               phase_tc;
    logic [CNT_W-1:0]   phase_tc_val;
    logic               frame_end;
    logic               accept;
    logic [DIGITS-1:0]  dark_mask;

    assign phase_tc_val = (state_q == ST_BLANK) ? BLANK_TC : DWELL_TC;
    assign frame_end    = (state_q == ST_SHOW) && (idx_q == LAST_IDX) && phase_tc;
    assign accept       = upd_valid && !pend_vld_q;
    assign seg_data     = seg_data_q;

    seg_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .tc_val  (phase_tc_val),
        .tc      (phase_tc)
    );

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            seg_data_q <= seg_data_d;
        end
    end

    // Next-state: phase sequencing, pending-slot handshake and frame-end swap.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        seg_data_d = seg_data_q;

        if (phase_tc) begin
            if (state_q == ST_BLANK) begin
                state_d = ST_SHOW;
            end else begin
                state_d = ST_BLANK;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end
        end

        if (accept) begin
            pending_d  = upd_data;
            pend_vld_d = 1'b1;
        end

        // accept and consume are exclusive, so a word taken in the frame-end
        // cycle waits a whole frame.
        if (frame_end && pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
        end

        // Load the next digit's nibble on BLANK entry, from the word that
        // will be active then, so a new word shows from digit 0 onwards.
        if ((state_q == ST_SHOW) && phase_tc) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_d == IDX_W'(k)) seg_data_d = active_d[k*SEG_NIB_W +: SEG_NIB_W];
            end
        end
    end

`ifdef SEG_LZB_EN
    logic zero_above;

    // Mark upper digits whose nibble and every higher nibble are zero.
    always_comb begin
        zero_above = 1'b1;
        dark_mask  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (active_q[k*SEG_NIB_W +: SEG_NIB_W] == '0);
            if (k != 0) dark_mask[k] = zero_above;
        end
    end
`else
    assign dark_mask = '0;
`endif

    // Outputs: decoded from registered state so reset forces them at once.
    always_comb begin
        seg_sel    = ALL_OFF[DIGITS-1:0];
        upd_ready  = !pend_vld_q;
        frame_done = frame_end;
        if (state_q == ST_SHOW) begin
            for (int k = 0; k < DIGITS; k++) begin
                if ((idx_q == IDX_W'(k)) && !dark_mask[k]) seg_sel[k] = 1'b0;
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller that shares one `seg` BCD-to-7-segment decoder across `DIGITS` common-anode digit positions. Holds a displayed BCD word, accepts tear-free updates through a valid/ready handshake applied only at frame boundaries, and sequences each digit through a blanking gap and a dwell window. Sits between the application's BCD value source and the single decoder instance that drives the segment pins.

## Interface
- `DIGITS`, 4: number of digit positions, 2..8.
- `DWELL_CYC`, 50000: `sys_clk` cycles each digit is lit per frame, ≥1.
- `BLANK_CYC`, 500: `sys_clk` cycles with all digits off before each dwell, ≥1.

- `sys_clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `upd_valid` in 1: new display word offered.
- `upd_data` in 4*DIGITS: packed BCD; nibble k = digit k; digit 0 is rightmost.
- `upd_ready` out 1: pending slot empty; a word is accepted when `upd_valid && upd_ready` at a clock edge.
- `seg_data` out 4: BCD nibble of the digit currently addressed; feeds decoder `seg_data`.
- `seg_sel` out DIGITS: digit enables, active-low; at most one bit low at any time.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Registers: `active` (displayed word), `pending` + `pend_vld`, digit index `idx`, phase counter `cnt`, state.
- States: `BLANK` (all `seg_sel` high, `cnt` counts to BLANK_CYC-1) -> `SHOW` (`seg_sel[idx]` low, `cnt` counts to DWELL_CYC-1) -> `BLANK` with `idx`+1; after `SHOW` of `idx = DIGITS-1`, `idx` wraps to 0.
- `seg_data = active[4*idx +: 4]`, registered; updates on entry to `BLANK` of each digit, so it is stable throughout that digit's `BLANK` and `SHOW`.
- Handshake: accepted word goes to `pending`, `pend_vld` set, `upd_ready` = `!pend_vld`. At the frame-end cycle (last `SHOW` cycle of digit DIGITS-1), if `pend_vld` then `active <= pending`, `pend_vld` cleared.
- A word accepted in the frame-end cycle itself is applied at the following frame end, not the current one.
- Non-BCD nibbles (>9) are passed through unchanged; the decoder shows "0" for them.
- `cnt` width = `$clog2(max(DWELL_CYC, BLANK_CYC))`; `idx` width = `$clog2(DIGITS)`. Both reset to 0 on wrap, with no overflow.

## Timing
- Reset values: state `BLANK`, `idx` 0, `cnt` 0, `active` 0, `pend_vld` 0, `seg_data` 0, `seg_sel` all ones, `upd_ready` 1, `frame_done` 0.
- After reset deassert: `seg_sel[0]` goes low after exactly BLANK_CYC cycles.
- Frame length = DIGITS × (BLANK_CYC + DWELL_CYC) cycles. `frame_done` is high in the final cycle, then `seg_sel` is all ones on the next cycle.
- Update latency: acceptance to `upd_ready` low = 1 cycle. Frame end to `active` visible on `seg_data` = next digit-0 `BLANK` entry, which is the cycle after the frame end.
- `upd_ready` returns high the cycle after the frame end that consumed `pending`.
- Reset asserted mid-frame: all outputs immediately take their reset values, and the pending word is discarded.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking. During `SHOW`, `seg_sel[idx]` stays high when `idx ≠ 0` and every nibble of `active` from `idx` up to DIGITS-1 is 0. Digit 0 always lights. Timing is unchanged, and the dwell slot is simply dark.
- Not defined: every digit lights in its `SHOW` window regardless of value.

## Structure
- Shared package `seg_pkg`: state enum (`ST_BLANK`, `ST_SHOW`), BCD nibble width constant (4), and the all-off select constant helper.
- One natural sub-module: `seg_phase_cnt`, the loadable phase counter with a terminal-count output. It is instantiated once, with its terminal value muxed between BLANK_CYC-1 and DWELL_CYC-1.
- The `seg` decoder is instantiated at the top level by the integrator, not inside this block.

## Test plan
Use DIGITS=4, DWELL_CYC=4, BLANK_CYC=2, so one frame is 24 cycles.
- Reset, then release -> `seg_sel`=4'b1111 for 2 cycles, then 4'b1110 for 4 cycles, 4'b1111 for 2 cycles, 4'b1101 next; `frame_done` pulses at cycle 24.
- Offer `upd_data`=16'h1234 mid-frame -> `upd_ready` falls next cycle. `seg_data` stays 0 until the frame end, then shows 4,3,2,1 for digits 0..3; `upd_ready` rises after the frame end.
- Offer a second word 16'h5678 while `pend_vld` is set -> not accepted. Hold valid -> accepted after `upd_ready` rises, and shown one frame later.
- `upd_valid` exactly in the frame-end cycle with `upd_ready`=1 -> applied at the next frame end, not the current one.
- Pulse `rst_n` low during digit 2 `SHOW` -> the same cycle shows `seg_sel`=4'b1111, `seg_data`=0, `upd_ready`=1; the scan restarts at digit 0.
- With `SEG_LZB_EN` and active word 16'h0070 -> digits 3 and 2 are never enabled, digit 1 shows 7, and digit 0 shows 0 and is enabled; with 16'h0000 only digit 0 lights.
